uart_rcv: RTL and testbench

- 8N1 UART receiver for the serial link.
- Consumes the serial line driven by the UART transmitter at the far end and recovers bytes from it.
- Presents each recovered byte on a parallel bus with a sticky rdy flag, plus framing and overrun status, for the command-processing logic.
- Runs at 2604 clk per bit: 50 MHz clock, 19200 baud.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rcv.sv | 140 ++++++++++++++
 tb/tb_uart_rcv.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and link-wide constants
// common to the transmitter and receiver.
package uart_pkg;

  localparam int UART_BAUD_DIV  = 2604;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both stages take
// RESET_VAL on reset so an idle line does not look like an edge.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rcv.sv
// 8N1 UART receiver: samples mid-bit using a half-period start delay, then
// presents each byte with sticky rdy / framing / overrun status.
module uart_rcv
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err
);

  localparam logic [11:0] BAUD_RELOAD = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_RELOAD = 12'(HALF_DIV - 1);
  localparam logic [3:0]  LAST_BIT    = 4'(UART_DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (RX),
    .q     (rx_s)
  );

  rx_state_t   state_q, state_d;
  logic [11:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_reg_q, shift_reg_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rdy_q, rdy_d;
  logic        frm_err_q, frm_err_d;
  logic        ovr_err_q, ovr_err_d;
  logic        seen_high_q, seen_high_d;
  logic        done;

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_reg_d = shift_reg_q;
    rx_data_d   = rx_data_q;
    seen_high_d = seen_high_q;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        baud_cnt_d = 12'd0;
        if (rx_s) begin
          seen_high_d = 1'b1;
        end
        // A stop bit still held low must go high before a new start counts
        if (!rx_s && seen_high_q) begin
          baud_cnt_d = HALF_RELOAD;
          state_d    = START;
        end
      end
      START: begin
        if (baud_cnt_q != 12'd0) begin
          baud_cnt_d = baud_cnt_q - 12'd1;
        end else if (rx_s) begin
          state_d = IDLE;
        end else begin
          baud_cnt_d = BAUD_RELOAD;
          bit_cnt_d  = 4'd0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (baud_cnt_q != 12'd0) begin
          baud_cnt_d = baud_cnt_q - 12'd1;
        end else begin
          shift_reg_d = {rx_s, shift_reg_q[7:1]};
          baud_cnt_d  = BAUD_RELOAD;
          bit_cnt_d   = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (baud_cnt_q != 12'd0) begin
          baud_cnt_d = baud_cnt_q - 12'd1;
        end else begin
          done        = 1'b1;
          rx_data_d   = shift_reg_q;
          seen_high_d = rx_s;
          baud_cnt_d  = 12'd0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Set beats clear when a byte completes in the same cycle as clr_rdy
    rdy_d     = done ? 1'b1 : (clr_rdy ? 1'b0 : rdy_q);
    frm_err_d = done ? (~rx_s | (frm_err_q & ~clr_rdy))
                     : (clr_rdy ? 1'b0 : frm_err_q);
    ovr_err_d = (done && rdy_q && !clr_rdy) ? 1'b1
              : (clr_rdy ? 1'b0 : ovr_err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_cnt_q  <= 12'd0;
      bit_cnt_q   <= 4'd0;
      shift_reg_q <= 8'h00;
      rx_data_q   <= 8'h00;
      rdy_q       <= 1'b0;
      frm_err_q   <= 1'b0;
      ovr_err_q   <= 1'b0;
      seen_high_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_reg_q <= shift_reg_d;
      rx_data_q   <= rx_data_d;
      rdy_q       <= rdy_d;
      frm_err_q   <= frm_err_d;
      ovr_err_q   <= ovr_err_d;
      seen_high_q <= seen_high_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign frm_err = frm_err_q;
  assign ovr_err = ovr_err_q;

endmodule

// File: tb/tb_uart_rcv.sv
// Scoreboard bench for uart_rcv at a reduced bit period: stimulus pushes the
// expected byte/flags, a negedge monitor pops and compares on each delivery.
module tb_uart_rcv;
  import uart_pkg::*;

  localparam int B   = 64;
  localparam int H   = B / 2;
  localparam int LAT = 9 * B + H + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RX = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;

  uart_rcv #(.BAUD_DIV(B)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .ovr_err (ovr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       frm;
    logic       ovr;
    bit         chk_lat;
    int         start_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a delivery is a rdy rise, or a new byte landing while rdy stays high
  logic       prev_rdy = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_ovr = 1'b0;
  always @(negedge clk) begin
    if (rst_n && rdy === 1'b1 &&
        (!prev_rdy || rx_data !== prev_data || (ovr_err && !prev_ovr))) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_byte: got %02h with no byte expected", rx_data);
      end else begin
        exp_t e;
        int   d;
        e = sb.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e.data));
        chk("frm_err", 32'(frm_err), 32'(e.frm));
        chk("ovr_err", 32'(ovr_err), 32'(e.ovr));
        if (e.chk_lat) begin
          d = cyc - e.start_cyc;
          chk("latency", (d >= LAT - 1 && d <= LAT + 1) ? 32'(LAT) : 32'(d), 32'(LAT));
        end
        $display("byte %02h frm=%0b ovr=%0b (expected %02h frm=%0b ovr=%0b)",
                 rx_data, frm_err, ovr_err, e.data, e.frm, e.ovr);
      end
    end
    prev_rdy  = rdy;
    prev_data = rx_data;
    prev_ovr  = ovr_err;
  end

  // All tasks assume entry just after a rising edge (edge + #1)
  task automatic drive_frame(input logic [7:0] d, input logic stop);
    RX = 1'b0;
    repeat (B) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (B) @(posedge clk);
      #1;
    end
    RX = stop;
    repeat (B) @(posedge clk);
    #1;
    RX = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input logic ef,
                           input logic eo, input bit lat);
    exp_t e;
    e.data      = d;
    e.frm       = ef;
    e.ovr       = eo;
    e.chk_lat   = lat;
    e.start_cyc = cyc;
    sb.push_back(e);
    drive_frame(d, stop);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    idle(1);
    clr_rdy = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20 * B) begin
      @(posedge clk);
      n++;
    end
    if (n != 0) #1;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: %0d bytes outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  // clr_rdy high during the cycle whose closing edge is the done pulse of a frame
  task automatic clr_at(input int edges);
    repeat (edges - 1) @(posedge clk);
    #1 clr_rdy = 1'b1;
    @(posedge clk);
    #1 clr_rdy = 1'b0;
  endtask

  initial begin
    logic [7:0] loop_bytes [4];
    loop_bytes[0] = 8'h00;
    loop_bytes[1] = 8'hFF;
    loop_bytes[2] = 8'h55;
    loop_bytes[3] = 8'h3C;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_rdy", 32'(rdy), 0);
    chk("reset_frm_err", 32'(frm_err), 0);
    chk("reset_ovr_err", 32'(ovr_err), 0);

    // Single byte with latency check; clr_rdy clears flags but keeps data
    send_byte(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_drain("a5");
    pulse_clr();
    chk("clr_rdy_rdy", 32'(rdy), 0);
    chk("clr_keeps_data", 32'(rx_data), 32'hA5);
    idle(B);

    // Back-to-back loopback, clr_rdy about 10 clk after each rdy
    for (int i = 0; i < 4; i++) begin
      fork
        send_byte(loop_bytes[i], 1'b1, 1'b0, 1'b0, 1'b0);
        clr_at(LAT + 10);
      join
    end
    wait_drain("loopback");
    idle(B);

    // Short low pulse is a false start
    RX = 1'b0;
    idle(H / 2);
    RX = 1'b1;
    idle(2 * B);
    chk("glitch_rdy", 32'(rdy), 0);
    chk("glitch_state", 32'(dut.state_q), 32'(IDLE));
    send_byte(8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_drain("after_glitch");
    pulse_clr();
    idle(B);

    // Framing error is sticky across a following good byte
    send_byte(8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(B);
    send_byte(8'h42, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_drain("framing");
    pulse_clr();
    chk("frm_err_cleared", 32'(frm_err), 0);
    idle(B);

    // Overrun without clear, then clear coinciding with the second done pulse
    send_byte(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_drain("overrun");
    pulse_clr();
    idle(B);
    send_byte(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    fork
      send_byte(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
      clr_at(LAT);
    join
    wait_drain("clr_on_done");
    idle(B);

    // Asynchronous reset in the middle of bit 4 of 0xF0
    fork
      drive_frame(8'hF0, 1'b1);
      begin
        repeat (5 * B + 10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rx_data", 32'(rx_data), 32'h00);
        chk("async_rst_rdy", 32'(rdy), 0);
        chk("async_rst_frm_err", 32'(frm_err), 0);
        chk("async_rst_ovr_err", 32'(ovr_err), 0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    idle(B);
    send_byte(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_drain("after_reset");
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
